// File: rtl/dsp_addsub_pkg.sv
// Opcode encoding shared by the pipelined add/subtract/accumulate unit,
// its lane slices, its bus interface and its testbench.
package dsp_addsub_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_ADD  = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB  = 2'b01;
    localparam logic [OP_W-1:0] OP_ACC  = 2'b10;
    localparam logic [OP_W-1:0] OP_LOAD = 2'b11;

endpackage

// File: rtl/dsp_addsub_pipe_if.sv
// Valid/ready operation and result bus of the add/subtract/accumulate unit.
// The master drives operations and accepts results; the slave is the unit.
interface dsp_addsub_pipe_if #(
    parameter int WIDTH = 32
);
    import dsp_addsub_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_overflow;
    logic             out_zero;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_carry, out_overflow, out_zero
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_carry, out_overflow, out_zero
    );

endinterface

// File: rtl/dsp_lane.sv
// One LANE_W-bit carry-chain segment: selects the effective addends for the
// opcode, adds them with carry-in, and registers sum, carry and its acc slice.
module dsp_lane
    import dsp_addsub_pkg::*;
#(
    parameter int LANE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              valid,
    input  logic [OP_W-1:0]   op,
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              cin,
    output logic [LANE_W-1:0] sum_d,
    output logic [LANE_W-1:0] sum_q,
    output logic              carry_q,
    output logic              overflow_d
);

    logic [LANE_W-1:0] x;
    logic [LANE_W-1:0] y;
    logic [LANE_W-1:0] acc_d;
    logic [LANE_W-1:0] acc_q;
    logic              carry_d;

    // LOAD passes A through as A + 0, which also forces carry and overflow to 0.
    always_comb begin
        x = a;
        y = '0;
        case (op)
            OP_ADD:  y = b;
            OP_SUB:  y = ~b;
            OP_ACC: begin
                x = acc_q;
                y = a;
            end
            default: y = '0;
        endcase

        {carry_d, sum_d} = {1'b0, x} + {1'b0, y} + {{LANE_W{1'b0}}, cin};
        overflow_d = (x[LANE_W-1] == y[LANE_W-1]) && (sum_d[LANE_W-1] != x[LANE_W-1]);

        acc_d = acc_q;
        if (valid && (op == OP_ACC || op == OP_LOAD)) begin
            acc_d = sum_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
        end else if (en) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/dsp_addsub_pipe.sv
// Pipelined WIDTH-bit add/subtract/accumulate unit: lane k of every operation
// is computed in stage k, with skewed operands in and deskewed results out.
module dsp_addsub_pipe
    import dsp_addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LANE_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dsp_addsub_pipe_if.slave     bus
);

    localparam int LANES = WIDTH / LANE_W;

    logic              adv;
    logic              valid_d  [LANES];
    logic              valid_q  [LANES];
    logic [OP_W-1:0]   op_d     [LANES];
    logic [OP_W-1:0]   op_q     [LANES];
    logic [WIDTH-1:0]  a_d      [LANES];
    logic [WIDTH-1:0]  a_q      [LANES];
    logic [WIDTH-1:0]  b_d      [LANES];
    logic [WIDTH-1:0]  b_q      [LANES];
    logic [WIDTH-1:0]  low_d    [LANES];
    logic [WIDTH-1:0]  low_q    [LANES];
    logic [WIDTH-1:0]  view     [LANES];
    logic [LANE_W-1:0] lane_sum_d   [LANES];
    logic [LANE_W-1:0] lane_sum_q   [LANES];
    logic              lane_carry_q [LANES];
    logic              lane_ovf_d   [LANES];
    logic              lane_cin     [LANES];
    logic              zero_d;
    logic              zero_q;
    logic              ovf_d;
    logic              ovf_q;

    assign adv = !valid_q[LANES-1] || bus.out_ready;

    // Stage k sees the op that left stage k-1, including its full operand skew copy.
    always_comb begin
        valid_d[0] = bus.in_valid;
        op_d[0]    = bus.in_op;
        a_d[0]     = bus.in_a;
        b_d[0]     = bus.in_b;
        for (int s = 1; s < LANES; s++) begin
            valid_d[s] = valid_q[s-1];
            op_d[s]    = op_q[s-1];
            a_d[s]     = a_q[s-1];
            b_d[s]     = b_q[s-1];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        if (k == 0) begin : g_first
            assign lane_cin[k] = (op_d[0] == OP_SUB);
        end else begin : g_chain
            assign lane_cin[k] = lane_carry_q[k-1];
        end

        dsp_lane #(
            .LANE_W (LANE_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .en         (adv),
            .valid      (valid_d[k]),
            .op         (op_d[k]),
            .a          (a_d[k][k*LANE_W +: LANE_W]),
            .b          (b_d[k][k*LANE_W +: LANE_W]),
            .cin        (lane_cin[k]),
            .sum_d      (lane_sum_d[k]),
            .sum_q      (lane_sum_q[k]),
            .carry_q    (lane_carry_q[k]),
            .overflow_d (lane_ovf_d[k])
        );
    end

    // view[s] is the result assembled so far (lanes 0..s) for the op leaving stage s.
    always_comb begin
        for (int s = 0; s < LANES; s++) begin
            view[s] = low_q[s] | (WIDTH'(lane_sum_q[s]) << (s * LANE_W));
        end
    end

    always_comb begin
        low_d[0] = '0;
        for (int s = 1; s < LANES; s++) begin
            low_d[s] = view[s-1];
        end
    end

    always_comb begin
        zero_d = ((low_d[LANES-1] | (WIDTH'(lane_sum_d[LANES-1]) << ((LANES - 1) * LANE_W))) == '0);
        ovf_d  = lane_ovf_d[LANES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LANES; s++) begin
                valid_q[s] <= 1'b0;
                op_q[s]    <= OP_ADD;
                a_q[s]     <= '0;
                b_q[s]     <= '0;
                low_q[s]   <= '0;
            end
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            for (int s = 0; s < LANES; s++) begin
                valid_q[s] <= valid_d[s];
                op_q[s]    <= op_d[s];
                a_q[s]     <= a_d[s];
                b_q[s]     <= b_d[s];
                low_q[s]   <= low_d[s];
            end
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.in_ready     = adv;
    assign bus.out_valid    = valid_q[LANES-1];
    assign bus.out_result   = view[LANES-1];
    assign bus.out_carry    = lane_carry_q[LANES-1];
    assign bus.out_overflow = ovf_q;
    assign bus.out_zero     = zero_q;

endmodule

// File: tb/tb_dsp_addsub_pipe.sv
// Scoreboard bench for dsp_addsub_pipe: directed cases on a 32-bit unit and
// randomized traffic on a 64-bit unit, both checked against a word-level model.
module tb_dsp_addsub_pipe;
    import dsp_addsub_pkg::*;

    localparam int W0 = 32;
    localparam int W1 = 64;
    localparam int LW = 16;
    localparam int L0 = W0 / LW;
    localparam int L1 = W1 / LW;

    typedef struct {
        logic [127:0] result;
        logic         carry;
        logic         ovf;
        logic         zero;
        int           issued;
        bit           exact;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dsp_addsub_pipe_if #(.WIDTH(W0)) bus0 ();
    dsp_addsub_pipe_if #(.WIDTH(W1)) bus1 ();

    dsp_addsub_pipe #(.WIDTH(W0), .LANE_W(LW)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    dsp_addsub_pipe #(.WIDTH(W1), .LANE_W(LW)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int           n_vec  = 0;
    int           n_fail = 0;
    int           cycle  = 0;
    int           ready_mode [2] = '{0, 0};
    logic [127:0] acc_model  [2] = '{128'd0, 128'd0};
    exp_t         q0 [$];
    exp_t         q1 [$];
    logic         held0 = 1'b0;
    logic         held1 = 1'b0;
    logic [35:0]  snap0;
    logic [67:0]  snap1;

    always @(posedge clk) cycle++;

    // Word-level reference: plain modulo-2^w arithmetic on the effective addends.
    function automatic exp_t ref_model(input int w, input logic [1:0] op,
                                       input logic [127:0] a_in, input logic [127:0] b_in,
                                       input logic [127:0] acc);
        exp_t        e;
        logic [128:0] mask;
        logic [128:0] x;
        logic [128:0] y;
        logic [128:0] full;
        logic [128:0] cin;
        mask = (129'd1 << w) - 129'd1;
        cin  = '0;
        case (op)
            OP_ADD: begin x = {1'b0, a_in} & mask; y = {1'b0, b_in} & mask; end
            OP_SUB: begin x = {1'b0, a_in} & mask; y = ~{1'b0, b_in} & mask; cin = 129'd1; end
            OP_ACC: begin x = {1'b0, acc} & mask; y = {1'b0, a_in} & mask; end
            default: begin x = {1'b0, a_in} & mask; y = '0; end
        endcase
        full     = x + y + cin;
        e.result = full[127:0] & mask[127:0];
        e.carry  = full[w];
        e.ovf    = (x[w-1] == y[w-1]) && (e.result[w-1] != x[w-1]);
        e.zero   = (e.result == 128'd0);
        e.issued = 0;
        e.exact  = 1'b0;
        return e;
    endfunction

    function automatic logic next_ready(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'b0;
        return ($urandom_range(0, 3) != 0);
    endfunction

    function automatic logic [127:0] rand_operand(input int w);
        logic [127:0] r;
        logic [127:0] ones;
        ones = '1;
        case ($urandom_range(0, 7))
            0: r = '0;
            1: r = ones;
            2: r = (128'd1 << (w - 1)) - 128'd1;
            3: r = 128'd1 << (w - 1);
            default: r = {$urandom, $urandom, $urandom, $urandom};
        endcase
        return r;
    endfunction

    task automatic check_value(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Present one op, wait (bounded) for acceptance, and record what it must produce.
    task automatic applyStimulus(input int sel, input logic [1:0] op,
                                 input logic [127:0] a_in, input logic [127:0] b_in, input bit exact);
        exp_t e;
        bit   rdy;
        int   budget;
        if (sel == 0) begin
            bus0.in_valid = 1'b1; bus0.in_op = op; bus0.in_a = a_in[W0-1:0]; bus0.in_b = b_in[W0-1:0];
        end else begin
            bus1.in_valid = 1'b1; bus1.in_op = op; bus1.in_a = a_in[W1-1:0]; bus1.in_b = b_in[W1-1:0];
        end
        budget = 0;
        do begin
            @(negedge clk);
            rdy = (sel == 0) ? bus0.in_ready : bus1.in_ready;
            budget++;
        end while (!rdy && budget < 200);
        if (!rdy) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0 on unit %0d", sel);
        end else begin
            e = ref_model((sel == 0) ? W0 : W1, op, a_in, b_in, acc_model[sel]);
            e.issued = cycle;
            e.exact  = exact;
            if (op == OP_ACC || op == OP_LOAD) acc_model[sel] = e.result;
            if (sel == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sel == 0) bus0.in_valid = 1'b0; else bus1.in_valid = 1'b0;
    endtask

    task automatic checkOutput(input int sel, input logic [127:0] res, input logic c,
                               input logic v, input logic z);
        exp_t e;
        int   lanes;
        lanes = (sel == 0) ? L0 : L1;
        n_vec++;
        if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
            n_fail++;
            $display("[TB] FAIL unexpected_output: unit %0d result %h with nothing outstanding", sel, res);
        end else begin
            e = (sel == 0) ? q0.pop_front() : q1.pop_front();
            if ({res, c, v, z} !== {e.result, e.carry, e.ovf, e.zero}) begin
                n_fail++;
                $display("[TB] FAIL result_u%0d: got %h c%b v%b z%b, expected %h c%b v%b z%b",
                         sel, res, c, v, z, e.result, e.carry, e.ovf, e.zero);
            end
            if (e.exact) begin
                n_vec++;
                if (cycle - e.issued != lanes) begin
                    n_fail++;
                    $display("[TB] FAIL latency_u%0d: got %0d cycles, expected %0d", sel, cycle - e.issued, lanes);
                end
            end
        end
    endtask

    // Monitor: stalled outputs must not move; accepted outputs are scored in order.
    always @(negedge clk) begin
        if (rst) begin
            held0 = 1'b0;
            held1 = 1'b0;
        end else begin
            if (held0) begin
                n_vec++;
                if ({bus0.out_valid, bus0.out_result, bus0.out_carry, bus0.out_overflow, bus0.out_zero} !== snap0) begin
                    n_fail++;
                    $display("[TB] FAIL stall_hold_u0: got %h, expected %h",
                             {bus0.out_valid, bus0.out_result, bus0.out_carry, bus0.out_overflow, bus0.out_zero}, snap0);
                end
            end
            if (held1) begin
                n_vec++;
                if ({bus1.out_valid, bus1.out_result, bus1.out_carry, bus1.out_overflow, bus1.out_zero} !== snap1) begin
                    n_fail++;
                    $display("[TB] FAIL stall_hold_u1: got %h, expected %h",
                             {bus1.out_valid, bus1.out_result, bus1.out_carry, bus1.out_overflow, bus1.out_zero}, snap1);
                end
            end
            held0 = bus0.out_valid && !bus0.out_ready;
            held1 = bus1.out_valid && !bus1.out_ready;
            snap0 = {bus0.out_valid, bus0.out_result, bus0.out_carry, bus0.out_overflow, bus0.out_zero};
            snap1 = {bus1.out_valid, bus1.out_result, bus1.out_carry, bus1.out_overflow, bus1.out_zero};
            if (bus0.out_valid && bus0.out_ready)
                checkOutput(0, {96'd0, bus0.out_result}, bus0.out_carry, bus0.out_overflow, bus0.out_zero);
            if (bus1.out_valid && bus1.out_ready)
                checkOutput(1, {64'd0, bus1.out_result}, bus1.out_carry, bus1.out_overflow, bus1.out_zero);
        end
    end

    initial begin
        bus0.out_ready = 1'b1;
        bus1.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus0.out_ready = next_ready(ready_mode[0]);
            bus1.out_ready = next_ready(ready_mode[1]);
        end
    end

    task automatic drain_all();
        int budget;
        budget = 0;
        while ((q0.size() != 0 || q1.size() != 0) && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL drain_timeout: %0d / %0d results never appeared", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_op = OP_ADD; bus0.in_a = '0; bus0.in_b = '0;
        bus1.in_valid = 1'b0; bus1.in_op = OP_ADD; bus1.in_a = '0; bus1.in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_value("reset_in_ready",   {127'd0, bus0.in_ready},     128'd1);
        check_value("reset_out_valid",  {127'd0, bus0.out_valid},    128'd0);
        check_value("reset_result",     {96'd0,  bus0.out_result},   128'd0);
        check_value("reset_carry",      {127'd0, bus0.out_carry},    128'd0);
        check_value("reset_overflow",   {127'd0, bus0.out_overflow}, 128'd0);
        check_value("reset_zero",       {127'd0, bus0.out_zero},     128'd0);
        check_value("reset_valid_u1",   {127'd0, bus1.out_valid},    128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] SUB streaming, signed overflow, accumulator chain");
        applyStimulus(0, OP_SUB,  128'h0001_0000, 128'h0000_0001, 1'b1);
        applyStimulus(0, OP_SUB,  128'h0000_0000, 128'h0000_0001, 1'b1);
        applyStimulus(0, OP_ADD,  128'h7FFF_FFFF, 128'h0000_0001, 1'b1);
        applyStimulus(0, OP_ADD,  128'hFFFF_FFFF, 128'h0000_0001, 1'b1);
        applyStimulus(0, OP_LOAD, 128'h0000_FFFF, 128'hDEAD_BEEF, 1'b1);
        applyStimulus(0, OP_ACC,  128'h0000_0001, 128'h1234_5678, 1'b1);
        applyStimulus(0, OP_ACC,  128'h0000_0001, 128'h0000_0000, 1'b1);
        applyStimulus(0, OP_ACC,  128'hFFFF_0000, 128'hFFFF_FFFF, 1'b1);
        drain_all();

        $display("[TB] backpressure with four ops");
        @(negedge clk);
        ready_mode[0] = 1;
        @(posedge clk);
        #2;
        fork
            begin
                applyStimulus(0, OP_LOAD, 128'h0000_0100, 128'h0, 1'b0);
                applyStimulus(0, OP_ACC,  128'h0000_0020, 128'h0, 1'b0);
                applyStimulus(0, OP_ADD,  128'h8000_0000, 128'h8000_0000, 1'b0);
                applyStimulus(0, OP_SUB,  128'h0000_0005, 128'h0000_0009, 1'b0);
            end
            begin
                repeat (4) @(negedge clk);
                check_value("stall_in_ready",  {127'd0, bus0.in_ready},  128'd0);
                check_value("stall_out_valid", {127'd0, bus0.out_valid}, 128'd1);
                @(negedge clk);
                ready_mode[0] = 0;
            end
        join
        applyStimulus(0, OP_ACC, 128'h0000_0003, 128'h0, 1'b1);
        drain_all();

        $display("[TB] reset with two ops in flight");
        applyStimulus(0, OP_LOAD, 128'h0000_0009, 128'h0, 1'b0);
        applyStimulus(0, OP_ACC,  128'h0000_0003, 128'h0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check_value("midreset_out_valid", {127'd0, bus0.out_valid}, 128'd0);
        check_value("midreset_in_ready",  {127'd0, bus0.in_ready},  128'd1);
        q0.delete();
        q1.delete();
        acc_model[0] = '0;
        acc_model[1] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(0, OP_ACC, 128'h0000_0005, 128'h0, 1'b1);
        drain_all();

        $display("[TB] 64-bit random traffic, output always ready");
        for (int i = 0; i < 150; i++) begin
            applyStimulus(1, 2'($urandom_range(0, 3)), rand_operand(W1), rand_operand(W1), 1'b1);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain_all();

        $display("[TB] 64-bit random traffic, random backpressure");
        ready_mode[1] = 2;
        for (int i = 0; i < 150; i++) begin
            applyStimulus(1, 2'($urandom_range(0, 3)), rand_operand(W1), rand_operand(W1), 1'b0);
        end
        ready_mode[1] = 0;
        drain_all();

        repeat (4) @(posedge clk);
        check_value("outstanding_u0", 128'(q0.size()), 128'd0);
        check_value("outstanding_u1", 128'(q1.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
